apb_gpio_irq: RTL and testbench

Parametrised APB GPIO port. It provides per-pin direction, pull-up and pull-down control, and atomic set/clear/toggle of the output register. Inputs pass through a multi-stage synchroniser, and each pin can raise a level- or edge-sensitive interrupt with sticky, write-1-to-clear status. It is an APB3 slave on the peripheral bus and drives pad-control wires plus one interrupt line to the system interrupt controller.

---
 rtl/apb_gpio_pkg.sv | 20 ++
 rtl/gpio_sync.sv | 33 +++
 rtl/apb_gpio_irq.sv | 166 ++++++++++++++++
 tb/tb_apb_gpio_irq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_pkg.sv
// apb_gpio_pkg: register offsets and decode index type for apb_gpio_irq.
// Offsets are word indices taken from PADDR[5:2].
package apb_gpio_pkg;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t DATA_OFF  = 4'h0;
  localparam reg_idx_t DIR_OFF   = 4'h1;
  localparam reg_idx_t PU_OFF    = 4'h2;
  localparam reg_idx_t PD_OFF    = 4'h3;
  localparam reg_idx_t SET_OFF   = 4'h4;
  localparam reg_idx_t CLR_OFF   = 4'h5;
  localparam reg_idx_t TGL_OFF   = 4'h6;
  localparam reg_idx_t IE_OFF    = 4'h7;
  localparam reg_idx_t ITYPE_OFF = 4'h8;
  localparam reg_idx_t IPOL_OFF  = 4'h9;
  localparam reg_idx_t ISTAT_OFF = 4'hA;
  localparam reg_idx_t RAWIN_OFF = 4'hB;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: per-bit reset-to-0 flop chain for asynchronous pad inputs.
// q_o is the last stage; depth is SYNC_STAGES.
module gpio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < SYNC_STAGES; i++)
      sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/apb_gpio_irq.sv
// apb_gpio_irq: APB3 GPIO port, synchronised inputs, per-pin interrupts.
// Define GPIO_IRQ_EN to build the IE/ITYPE/IPOL/ISTAT interrupt logic.
module apb_gpio_irq
  import apb_gpio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [31:0]      PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [WIDTH-1:0] GPIOIN,
  output logic [WIDTH-1:0] GPIOOUT,
  output logic [WIDTH-1:0] GPIOPU,
  output logic [WIDTH-1:0] GPIOPD,
  output logic [WIDTH-1:0] GPIOEN,
  output logic             IRQ
);

  reg_idx_t         idx;
  logic             wr;
  logic             mapped;
  logic             unused_bits;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] pu_q, pu_d;
  logic [WIDTH-1:0] pd_q, pd_d;

  assign idx         = PADDR[5:2];
  assign wr          = PSEL & PENABLE & PWRITE;
  assign wdata       = PWDATA[WIDTH-1:0];
  assign mapped      = (idx <= RAWIN_OFF);
  assign unused_bits = ^{PADDR[31:6], PADDR[1:0], PWDATA};

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .d_i    (GPIOIN),
    .q_o    (sync)
  );

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    pu_d  = pu_q;
    pd_d  = pd_q;
    if (wr) begin
      unique case (1'b1)
        idx == DATA_OFF: out_d = wdata;
        idx == DIR_OFF:  dir_d = wdata;
        idx == PU_OFF:   pu_d  = wdata;
        idx == PD_OFF:   pd_d  = wdata;
        idx == SET_OFF:  out_d = out_q | wdata;
        idx == CLR_OFF:  out_d = out_q & ~wdata;
        idx == TGL_OFF:  out_d = out_q ^ wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      out_q <= '0;
      dir_q <= '0;
      pu_q  <= '0;
      pd_q  <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      pu_q  <= pu_d;
      pd_q  <= pd_d;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] ie_q, ie_d;
  logic [WIDTH-1:0] itype_q, itype_d;
  logic [WIDTH-1:0] ipol_q, ipol_d;
  logic [WIDTH-1:0] istat_q, istat_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] w1c;

  // Level: pin at polarity. Edge: additionally away from it last cycle.
  assign ev = dir_q & ~(sync ^ ipol_q)
            & (~itype_q | (prev_q ^ ipol_q));

  always_comb begin
    ie_d    = ie_q;
    itype_d = itype_q;
    ipol_d  = ipol_q;
    w1c     = '0;
    if (wr) begin
      unique case (1'b1)
        idx == IE_OFF:    ie_d    = wdata;
        idx == ITYPE_OFF: itype_d = wdata;
        idx == IPOL_OFF:  ipol_d  = wdata;
        idx == ISTAT_OFF: w1c     = wdata;
        default: ;
      endcase
    end
    istat_d = ev | (istat_q & ~w1c);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ie_q    <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
      istat_q <= '0;
      prev_q  <= '0;
    end else begin
      ie_q    <= ie_d;
      itype_q <= itype_d;
      ipol_q  <= ipol_d;
      istat_q <= istat_d;
      prev_q  <= sync;
    end
  end

  assign IRQ = |(istat_q & ie_q);
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    rd = '0;
    unique case (1'b1)
      idx == DATA_OFF:  rd = (dir_q & sync) | (~dir_q & out_q);
      idx == DIR_OFF:   rd = dir_q;
      idx == PU_OFF:    rd = pu_q;
      idx == PD_OFF:    rd = pd_q;
`ifdef GPIO_IRQ_EN
      idx == IE_OFF:    rd = ie_q;
      idx == ITYPE_OFF: rd = itype_q;
      idx == IPOL_OFF:  rd = ipol_q;
      idx == ISTAT_OFF: rd = istat_q;
`endif
      idx == RAWIN_OFF: rd = sync;
      default:          rd = '0;
    endcase
    PRDATA            = '0;
    PRDATA[WIDTH-1:0] = rd;
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~mapped;
  assign GPIOOUT = out_q;
  assign GPIOPU  = pu_q;
  assign GPIOPD  = pd_q;
  assign GPIOEN  = dir_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// tb_apb_gpio_irq: directed and random APB/pin stimulus vs a register model.
// Interrupt expectations follow GPIO_IRQ_EN in the same way as the design.
module tb_apb_gpio_irq;

  localparam int W  = 16;
  localparam int SS = 2;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [31:0]   PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [W-1:0]  GPIOIN = '0;
  logic [W-1:0]  GPIOOUT, GPIOPU, GPIOPD, GPIOEN;
  logic          IRQ;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] m_out, m_dir, m_pu, m_pd;
  logic [W-1:0] m_ie, m_itype, m_ipol, m_istat;
  logic [W-1:0] hq[$];

  apb_gpio_irq #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .GPIOIN (GPIOIN),
    .GPIOOUT(GPIOOUT),
    .GPIOPU (GPIOPU),
    .GPIOPD (GPIOPD),
    .GPIOEN (GPIOEN),
    .IRQ    (IRQ)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_pu = '0; m_pd = '0;
    m_ie = '0; m_itype = '0; m_ipol = '0; m_istat = '0;
    hq = {};
    repeat (SS + 1) hq.push_front('0);
  endtask

  // hq[0] is the newest pad sample; SYNC is SS-1 samples back, PREV one more.
  task automatic model_step();
    logic [W-1:0] sy, pv, wd;
    int off;
    bit wr;
    if (!PRESETn) begin
      model_reset();
      return;
    end
    sy  = hq[SS-1];
    pv  = hq[SS];
    wd  = PWDATA[W-1:0];
    wr  = PSEL && PENABLE && PWRITE;
    off = int'(PADDR[5:2]);
    if (IRQ_ON) begin
      for (int i = 0; i < W; i++) begin
        if (m_dir[i] && sy[i] == m_ipol[i] &&
            (!m_itype[i] || pv[i] != m_ipol[i]))
          m_istat[i] = 1'b1;
        else if (wr && off == 10 && wd[i])
          m_istat[i] = 1'b0;
      end
    end
    if (wr) begin
      case (off)
        0: m_out = wd;
        1: m_dir = wd;
        2: m_pu  = wd;
        3: m_pd  = wd;
        4: m_out = m_out | wd;
        5: m_out = m_out & ~wd;
        6: m_out = m_out ^ wd;
        7: if (IRQ_ON) m_ie = wd;
        8: if (IRQ_ON) m_itype = wd;
        9: if (IRQ_ON) m_ipol = wd;
        default: ;
      endcase
    end
    hq.push_front(GPIOIN);
    void'(hq.pop_back());
  endtask

  function automatic logic [31:0] exp_rd(input int off);
    logic [W-1:0] sy;
    sy = hq[SS-1];
    case (off)
      0:  return 32'((m_dir & sy) | (~m_dir & m_out));
      1:  return 32'(m_dir);
      2:  return 32'(m_pu);
      3:  return 32'(m_pd);
      7:  return IRQ_ON ? 32'(m_ie) : 32'h0;
      8:  return IRQ_ON ? 32'(m_itype) : 32'h0;
      9:  return IRQ_ON ? 32'(m_ipol) : 32'h0;
      10: return IRQ_ON ? 32'(m_istat) : 32'h0;
      11: return 32'(sy);
      default: return 32'h0;
    endcase
  endfunction

  task automatic nxt();
    @(posedge PCLK);
    model_step();
    @(negedge PCLK);
  endtask

  task automatic check_outs();
    #1;
    chk("gpioout", 32'(GPIOOUT), 32'(m_out));
    chk("gpioen",  32'(GPIOEN),  32'(m_dir));
    chk("gpiopu",  32'(GPIOPU),  32'(m_pu));
    chk("gpiopd",  32'(GPIOPD),  32'(m_pd));
    chk("irq",     32'(IRQ),     32'(IRQ_ON && |(m_istat & m_ie)));
    chk("pready",  32'(PREADY),  32'h1);
  endtask

  function automatic logic [31:0] mk_addr(input int off);
    return ($urandom() & 32'hFFFF_FFC3) | (32'(off) << 2);
  endfunction

  task automatic apb_write(input int off, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = mk_addr(off); PWDATA = data;
    nxt();
    PENABLE = 1'b1;
    nxt();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input int off, output logic [31:0] data,
                          output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = mk_addr(off); PWDATA = $urandom();
    #1 chk("slverr_setup", 32'(PSLVERR), 32'h0);
    nxt();
    PENABLE = 1'b1;
    #1;
    data = PRDATA;
    err  = PSLVERR;
    chk($sformatf("rd_%0h", off * 4), PRDATA, exp_rd(off));
    chk($sformatf("slverr_%0h", off * 4), 32'(PSLVERR), 32'(off >= 12));
    nxt();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  logic [31:0] d;
  logic        e;

  initial begin
    model_reset();
    repeat (3) nxt();
    PRESETn = 1'b1;
    check_outs();
    chk("rst_en", 32'(GPIOEN), 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    for (int i = 0; i < 16; i++) apb_read(i, d, e);
    apb_read(13, d, e);
    chk("rd34_data", d, 32'h0);
    chk("rd34_err", 32'(e), 32'h1);

    apb_write(0, 32'h0000_00F0);
    apb_write(4, 32'h0000_0003);
    apb_write(5, 32'h0000_0010);
    apb_write(6, 32'hFFFF_8001);
    check_outs();
    chk("out_80e2", 32'(GPIOOUT), 32'h80E2);

    apb_write(4, 32'h1);
    apb_write(1, 32'h1);
    GPIOIN = '0;
    repeat (2) nxt();
    apb_read(0, d, e);
    chk("data_pin0_in", d, 32'h80E2);
    apb_write(1, 32'h0);
    check_outs();
    chk("out_retained", 32'(GPIOOUT), 32'h80E3);

    PADDR = 32'h2C;
    GPIOIN[0] = 1'b1;
    nxt();
    #1 chk("rawin_lat1", 32'(PRDATA[0]), 32'h0);
    nxt();
    #1 chk("rawin_lat2", 32'(PRDATA[0]), 32'h1);
    GPIOIN = '0;
    repeat (3) nxt();
    apb_write(10, 32'hFFFF);

    apb_write(8, 32'h8);
    apb_write(9, 32'h8);
    apb_write(1, 32'h8);
    apb_write(7, 32'h8);
    check_outs();
    GPIOIN[3] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      nxt();
      #1 chk($sformatf("irq_edge_c%0d", k), 32'(IRQ),
             32'(IRQ_ON && k == 3));
    end
    apb_read(10, d, e);
    chk("istat_edge", d, IRQ_ON ? 32'h8 : 32'h0);
    apb_write(10, 32'h8);
    #1 chk("irq_w1c_drop", 32'(IRQ), 32'h0);
    repeat (3) nxt();
    apb_read(10, d, e);
    chk("istat_hold_hi", d, 32'h0);

    GPIOIN[5] = 1'b0;
    apb_write(1, 32'h28);
    apb_write(7, 32'h28);
    repeat (2) nxt();
    apb_read(10, d, e);
    chk("istat_lvl", d, IRQ_ON ? 32'h20 : 32'h0);
    apb_write(10, 32'h20);
    #1 chk("irq_lvl_stays", 32'(IRQ), 32'(IRQ_ON));
    apb_read(10, d, e);
    chk("istat_lvl_reset", d, IRQ_ON ? 32'h20 : 32'h0);

    apb_write(1, 32'h8);
    GPIOIN[3] = 1'b0;
    repeat (4) nxt();
    apb_write(10, 32'hFFFF);
    check_outs();
    GPIOIN[3] = 1'b1;
    nxt();
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    PADDR = 32'h28; PWDATA = 32'h8;
    nxt();
    PENABLE = 1'b1;
    nxt();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check_outs();
    apb_read(10, d, e);
    chk("istat_set_wins", d & 32'h8, IRQ_ON ? 32'h8 : 32'h0);

    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    PADDR = 32'h0; PWDATA = 32'hFFFF;
    nxt();
    PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    model_reset();
    check_outs();
    chk("rst_mid_out", 32'(GPIOOUT), 32'h0);
    chk("rst_mid_en", 32'(GPIOEN), 32'h0);
    chk("rst_mid_irq", 32'(IRQ), 32'h0);
    chk("rst_mid_prdata", PRDATA, 32'h0);
    nxt();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    nxt();
    PRESETn = 1'b1;
    apb_read(10, d, e);
    chk("rst_istat", d, 32'h0);
    apb_read(0, d, e);
    chk("rst_data", d, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3)
        apb_write($urandom_range(0, 15), $urandom());
      else if (r <= 6)
        apb_read($urandom_range(0, 15), d, e);
      else if (r <= 8) begin
        if ($urandom_range(0, 1) == 1)
          GPIOIN = GPIOIN ^ W'(1 << $urandom_range(0, W - 1));
        else
          GPIOIN = W'($urandom());
        nxt();
      end else
        nxt();
      check_outs();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
